// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single DMEM port between the CPU and a DMA/loader.
// The CPU owns the port by default. A DMA request is granted when the CPU is
// idle, or after STARVE_LIMIT consecutive blocked cycles, in which case the
// CPU is stalled for that one cycle. A granted DMA access is acknowledged in
// the following cycle, during which the port is handed back to the CPU.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [2:0]  cpu_type,
  input  logic [11:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [2:0]  dma_type,
  input  logic [11:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        mem_ena,
  output logic        mem_wena,
  output logic        mem_rena,
  output logic [2:0]  mem_type,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [15:0] stall_count
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_DMA_RESP = 1'b1
  } state_t;

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_dma_rdata;
  logic [15:0] r_stall_count;

  logic w_in_idle;
  logic w_dma_grant;
  logic w_cpu_stall;

  // Saturating increment: the stall counter sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Grant is combinational so the DMA access happens in the request cycle.
  assign w_in_idle   = (r_state == S_IDLE);
  assign w_dma_grant = ~reset & w_in_idle & dma_req &
                       (~cpu_cs | (r_wait_cnt == LIMIT));
  assign w_cpu_stall = w_dma_grant & cpu_cs;

  assign cpu_stall   = w_cpu_stall;
  assign dma_ack     = ~reset & (r_state == S_DMA_RESP);
  assign dma_rdata   = r_dma_rdata;
  assign stall_count = r_stall_count;

  // Memory port mux: DMA fields when granted, CPU fields otherwise; strobes
  // are forced low while reset is held.
  always_comb begin
    mem_ena   = 1'b0;
    mem_wena  = 1'b0;
    mem_rena  = 1'b0;
    mem_type  = cpu_type;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (reset) begin
      mem_ena  = 1'b0;
      mem_wena = 1'b0;
      mem_rena = 1'b0;
    end else if (w_dma_grant) begin
      mem_ena   = 1'b1;
      mem_wena  = dma_we;
      mem_rena  = ~dma_we;
      mem_type  = dma_type;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else begin
      mem_ena  = cpu_cs;
      mem_wena = cpu_we;
      mem_rena = cpu_re;
    end
  end

  // Two-state FSM: a grant moves to DMA_RESP, which always returns to IDLE.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (w_dma_grant) r_state <= S_DMA_RESP;
        S_DMA_RESP: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // Starvation counter: counts blocked request cycles, cleared on grant or
  // when the request goes away.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_wait_cnt <= 8'd0;
    end else if (w_dma_grant || !dma_req) begin
      r_wait_cnt <= 8'd0;
    end else if (w_in_idle && cpu_cs && (r_wait_cnt < LIMIT)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // DMA read data is captured on the granted edge and held otherwise.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_dma_rdata <= 32'd0;
    end else if (w_dma_grant && !dma_we) begin
      r_dma_rdata <= mem_rdata;
    end
  end

  // Count cycles in which the CPU was forced to stall.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_stall_count <= 16'd0;
    end else if (w_cpu_stall) begin
      r_stall_count <= sat_inc16(r_stall_count);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (STARVE_LIMIT 8 and 1) share inputs.
// Expected DMA read data is queued when a request is driven and popped when
// the arbiter acknowledges it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_cs, cpu_we, cpu_re;
  logic [2:0]  cpu_type;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        dma_req, dma_we;
  logic [2:0]  dma_type;
  logic [11:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] mem_rdata;

  logic        o8_cpu_stall, o8_dma_ack, o8_mem_ena, o8_mem_wena, o8_mem_rena;
  logic [31:0] o8_dma_rdata, o8_mem_wdata;
  logic [2:0]  o8_mem_type;
  logic [11:0] o8_mem_addr;
  logic [15:0] o8_stall_count;

  logic        o1_cpu_stall, o1_dma_ack, o1_mem_ena, o1_mem_wena, o1_mem_rena;
  logic [31:0] o1_dma_rdata, o1_mem_wdata;
  logic [2:0]  o1_mem_type;
  logic [11:0] o1_mem_addr;
  logic [15:0] o1_stall_count;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_rdata;
  logic [15:0] m_stall8;

  dmem_arbiter #(.STARVE_LIMIT(8)) u8 (
    .clk_in(clk), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_type(cpu_type),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall(o8_cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_type(dma_type), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(o8_dma_ack), .dma_rdata(o8_dma_rdata),
    .mem_ena(o8_mem_ena), .mem_wena(o8_mem_wena), .mem_rena(o8_mem_rena),
    .mem_type(o8_mem_type), .mem_addr(o8_mem_addr), .mem_wdata(o8_mem_wdata),
    .mem_rdata(mem_rdata), .stall_count(o8_stall_count)
  );

  dmem_arbiter #(.STARVE_LIMIT(1)) u1 (
    .clk_in(clk), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_type(cpu_type),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall(o1_cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_type(dma_type), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(o1_dma_ack), .dma_rdata(o1_dma_rdata),
    .mem_ena(o1_mem_ena), .mem_wena(o1_mem_wena), .mem_rena(o1_mem_rena),
    .mem_type(o1_mem_type), .mem_addr(o1_mem_addr), .mem_wdata(o1_mem_wdata),
    .mem_rdata(mem_rdata), .stall_count(o1_stall_count)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    cpu_cs = 0; cpu_we = 0; cpu_re = 0; cpu_type = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_type = 0; dma_addr = 0; dma_wdata = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1; cpu_cs = 1; cpu_re = 1; dma_req = 1; mem_rdata = 32'h5555_5555;
    #2;
    n_vec++; if (o8_dma_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", o8_dma_ack); end
    n_vec++; if (o8_cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", o8_cpu_stall); end
    n_vec++; if (o8_mem_ena !== 1'b0) begin n_err++; $display("FAIL rst_ena: got %b want 0", o8_mem_ena); end
    n_vec++; if (o1_mem_ena !== 1'b0) begin n_err++; $display("FAIL rst_ena1: got %b want 0", o1_mem_ena); end
    @(negedge clk); #2;
    n_vec++; if (o8_stall_count !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %h want 0", o8_stall_count); end
    n_vec++; if (o8_dma_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", o8_dma_rdata); end
    n_vec++; if (o8_dma_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack2: got %b want 0", o8_dma_ack); end
    @(negedge clk);
    set_idle(); reset = 0;
    exp_q.delete(); m_rdata = 0; m_stall8 = 0;
    @(negedge clk);
  endtask

  task automatic test_dma_read();
    dma_req = 1; dma_we = 0; dma_type = 3'd0; dma_addr = 12'h010; mem_rdata = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    #2;
    n_vec++; if (o8_mem_rena !== 1'b1) begin n_err++; $display("FAIL rd_rena: got %b want 1", o8_mem_rena); end
    n_vec++; if (o8_mem_addr !== 12'h010) begin n_err++; $display("FAIL rd_addr: got %h want 010", o8_mem_addr); end
    n_vec++; if (o8_cpu_stall !== 1'b0) begin n_err++; $display("FAIL rd_stall: got %b want 0", o8_cpu_stall); end
    n_vec++; if (o8_dma_ack !== 1'b0) begin n_err++; $display("FAIL rd_early_ack: got %b want 0", o8_dma_ack); end
    @(negedge clk); mem_rdata = 32'h0; #2;
    n_vec++; if (o8_dma_ack !== 1'b1) begin n_err++; $display("FAIL rd_ack: got %b want 1", o8_dma_ack); end
    if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
    n_vec++; if (o8_dma_rdata !== m_rdata) begin n_err++; $display("FAIL rd_data: got %h want %h", o8_dma_rdata, m_rdata); end
    n_vec++; if (o8_mem_ena !== 1'b0) begin n_err++; $display("FAIL rd_resp_port: got %b want 0", o8_mem_ena); end
    n_vec++; if (o8_cpu_stall !== 1'b0) begin n_err++; $display("FAIL rd_stall2: got %b want 0", o8_cpu_stall); end
    dma_req = 0;
    @(negedge clk); #2;
    n_vec++; if (o8_dma_ack !== 1'b0) begin n_err++; $display("FAIL rd_ack_once: got %b want 0", o8_dma_ack); end
    @(negedge clk);
  endtask

  task automatic test_dma_write();
    dma_req = 1; dma_we = 1; dma_type = 3'd1; dma_addr = 12'h020; dma_wdata = 32'h12345678;
    mem_rdata = 32'hCAFEF00D;
    exp_q.push_back(m_rdata);
    #2;
    n_vec++; if (o8_mem_wena !== 1'b1) begin n_err++; $display("FAIL wr_wena: got %b want 1", o8_mem_wena); end
    n_vec++; if (o8_mem_rena !== 1'b0) begin n_err++; $display("FAIL wr_rena: got %b want 0", o8_mem_rena); end
    n_vec++; if (o8_mem_wdata !== 32'h12345678) begin n_err++; $display("FAIL wr_wdata: got %h want 12345678", o8_mem_wdata); end
    n_vec++; if (o8_mem_type !== 3'd1) begin n_err++; $display("FAIL wr_type: got %0d want 1", o8_mem_type); end
    n_vec++; if (o8_mem_addr !== 12'h020) begin n_err++; $display("FAIL wr_addr: got %h want 020", o8_mem_addr); end
    @(negedge clk); #2;
    n_vec++; if (o8_dma_ack !== 1'b1) begin n_err++; $display("FAIL wr_ack: got %b want 1", o8_dma_ack); end
    n_vec++; if (o8_mem_wena !== 1'b0) begin n_err++; $display("FAIL wr_wena_once: got %b want 0", o8_mem_wena); end
    if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
    n_vec++; if (o8_dma_rdata !== m_rdata) begin n_err++; $display("FAIL wr_rdata_hold: got %h want %h", o8_dma_rdata, m_rdata); end
    dma_req = 0; dma_we = 0; mem_rdata = 0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    cpu_cs = 1; cpu_re = 1; cpu_type = 3'd2; cpu_addr = 12'h100;
    dma_req = 1; dma_we = 0; dma_type = 3'd4; dma_addr = 12'h030; mem_rdata = 32'h0BADCAFE;
    exp_q.push_back(32'h0BADCAFE);
    for (int i = 0; i < 9; i++) begin
      #2;
      n_vec++; if (o8_cpu_stall !== (i == 8)) begin n_err++; $display("FAIL starve_stall c%0d: got %b want %b", i, o8_cpu_stall, (i == 8)); end
      n_vec++; if (o8_mem_addr !== ((i == 8) ? 12'h030 : 12'h100)) begin n_err++; $display("FAIL starve_addr c%0d: got %h", i, o8_mem_addr); end
      n_vec++; if (o8_mem_type !== ((i == 8) ? 3'd4 : 3'd2)) begin n_err++; $display("FAIL starve_type c%0d: got %0d", i, o8_mem_type); end
      n_vec++; if (o1_cpu_stall !== ((i % 3) == 1)) begin n_err++; $display("FAIL lim1_stall c%0d: got %b want %b", i, o1_cpu_stall, ((i % 3) == 1)); end
      @(negedge clk);
    end
    #2;
    n_vec++; if (o8_dma_ack !== 1'b1) begin n_err++; $display("FAIL starve_ack: got %b want 1", o8_dma_ack); end
    if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
    n_vec++; if (o8_dma_rdata !== m_rdata) begin n_err++; $display("FAIL starve_rdata: got %h want %h", o8_dma_rdata, m_rdata); end
    n_vec++; if (o8_cpu_stall !== 1'b0) begin n_err++; $display("FAIL starve_resp_stall: got %b want 0", o8_cpu_stall); end
    n_vec++; if (o8_mem_addr !== 12'h100) begin n_err++; $display("FAIL starve_resp_addr: got %h want 100", o8_mem_addr); end
    n_vec++; if (o1_cpu_stall !== 1'b0) begin n_err++; $display("FAIL lim1_stall c9: got %b want 0", o1_cpu_stall); end
    m_stall8 = m_stall8 + 16'd1;
    dma_req = 0;
    @(negedge clk); #2;
    n_vec++; if (o8_stall_count !== m_stall8) begin n_err++; $display("FAIL starve_cnt: got %0d want %0d", o8_stall_count, m_stall8); end
    n_vec++; if (o1_stall_count !== 16'd3) begin n_err++; $display("FAIL lim1_cnt: got %0d want 3", o1_stall_count); end
    cpu_cs = 0; cpu_re = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int acks;
    logic prev;
    logic [31:0] v;
    acks = 0; prev = 1'b0;
    dma_req = 1; dma_we = 0; dma_type = 3'd5; dma_addr = 12'h040;
    for (int i = 0; i < 10; i++) begin
      v = 32'hA000_0000 + 32'(i);
      mem_rdata = v;
      if ((i % 2) == 0) exp_q.push_back(v);
      #2;
      n_vec++; if (o8_dma_ack !== ((i % 2) == 1)) begin n_err++; $display("FAIL b2b_ack c%0d: got %b want %b", i + 1, o8_dma_ack, ((i % 2) == 1)); end
      if (o8_dma_ack === 1'b1) begin
        acks++;
        if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
        n_vec++; if (o8_dma_rdata !== m_rdata) begin n_err++; $display("FAIL b2b_rdata c%0d: got %h want %h", i + 1, o8_dma_rdata, m_rdata); end
        n_vec++; if (prev === 1'b1) begin n_err++; $display("FAIL b2b_consec c%0d: got 1 want 0", i + 1); end
      end
      prev = o8_dma_ack;
      if (i == 9) dma_req = 0;
      @(negedge clk);
    end
    n_vec++; if (acks != 5) begin n_err++; $display("FAIL b2b_count: got %0d want 5", acks); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_pending: got %0d want 0", exp_q.size()); end
    exp_q.delete();
    mem_rdata = 0;
    @(negedge clk);
  endtask

  task automatic test_drop_before_grant();
    cpu_cs = 1; cpu_re = 1; cpu_type = 3'd0; cpu_addr = 12'h200;
    dma_req = 1; dma_we = 0; dma_type = 3'd0; dma_addr = 12'h050; mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      #2;
      n_vec++; if (o8_cpu_stall !== 1'b0) begin n_err++; $display("FAIL drop_pre c%0d: got %b want 0", i, o8_cpu_stall); end
      @(negedge clk);
    end
    dma_req = 0; #2;
    n_vec++; if (o8_mem_addr !== 12'h200) begin n_err++; $display("FAIL drop_addr: got %h want 200", o8_mem_addr); end
    @(negedge clk); #2;
    n_vec++; if (o8_dma_ack !== 1'b0) begin n_err++; $display("FAIL drop_ack: got %b want 0", o8_dma_ack); end
    dma_req = 1;
    exp_q.push_back(32'h1111_2222);
    for (int i = 0; i < 9; i++) begin
      if (i != 0) #2;
      n_vec++; if (o8_cpu_stall !== (i == 8)) begin n_err++; $display("FAIL drop_wait c%0d: got %b want %b", i, o8_cpu_stall, (i == 8)); end
      @(negedge clk);
    end
    #2;
    n_vec++; if (o8_dma_ack !== 1'b1) begin n_err++; $display("FAIL drop_ack2: got %b want 1", o8_dma_ack); end
    if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
    n_vec++; if (o8_dma_rdata !== m_rdata) begin n_err++; $display("FAIL drop_rdata: got %h want %h", o8_dma_rdata, m_rdata); end
    m_stall8 = m_stall8 + 16'd1;
    dma_req = 0;
    @(negedge clk); #2;
    n_vec++; if (o8_stall_count !== m_stall8) begin n_err++; $display("FAIL drop_cnt: got %0d want %0d", o8_stall_count, m_stall8); end
    cpu_cs = 0; cpu_re = 0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int n;
    force u8.r_stall_count = 16'hFFFE;
    @(negedge clk);
    release u8.r_stall_count;
    m_stall8 = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      cpu_cs = 1; cpu_re = 1; cpu_addr = 12'h300;
      dma_req = 1; dma_we = 0; dma_addr = 12'h060 + 12'(k); mem_rdata = 32'h5A5A_0000 + 32'(k);
      exp_q.push_back(mem_rdata);
      n = 0;
      #2;
      while (o8_cpu_stall !== 1'b1 && n < 20) begin
        @(negedge clk); #2; n++;
      end
      n_vec++; if (n != 8) begin n_err++; $display("FAIL sat_blocked k%0d: got %0d want 8", k, n); end
      @(negedge clk); #2;
      n_vec++; if (o8_dma_ack !== 1'b1) begin n_err++; $display("FAIL sat_ack k%0d: got %b want 1", k, o8_dma_ack); end
      if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
      n_vec++; if (o8_dma_rdata !== m_rdata) begin n_err++; $display("FAIL sat_rdata k%0d: got %h want %h", k, o8_dma_rdata, m_rdata); end
      m_stall8 = (m_stall8 == 16'hFFFF) ? m_stall8 : m_stall8 + 16'd1;
      dma_req = 0;
      @(negedge clk); #2;
      n_vec++; if (o8_stall_count !== m_stall8) begin n_err++; $display("FAIL sat_cnt k%0d: got %h want %h", k, o8_stall_count, m_stall8); end
      @(negedge clk);
    end
    cpu_cs = 0; cpu_re = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_in_resp();
    int n;
    dma_req = 1; dma_we = 0; dma_addr = 12'h070; mem_rdata = 32'h7777_7777;
    #2;
    n_vec++; if (o8_mem_rena !== 1'b1) begin n_err++; $display("FAIL rir_grant: got %b want 1", o8_mem_rena); end
    @(negedge clk);
    reset = 1; cpu_cs = 1; cpu_re = 1; #2;
    n_vec++; if (o8_dma_ack !== 1'b0) begin n_err++; $display("FAIL rir_ack_during: got %b want 0", o8_dma_ack); end
    n_vec++; if (o8_cpu_stall !== 1'b0) begin n_err++; $display("FAIL rir_stall: got %b want 0", o8_cpu_stall); end
    n_vec++; if (o8_mem_ena !== 1'b0) begin n_err++; $display("FAIL rir_ena: got %b want 0", o8_mem_ena); end
    @(negedge clk);
    reset = 0; dma_req = 0; cpu_cs = 0; cpu_re = 0;
    exp_q.delete(); m_rdata = 0; m_stall8 = 0;
    #2;
    n_vec++; if (o8_dma_ack !== 1'b0) begin n_err++; $display("FAIL rir_ack_after: got %b want 0", o8_dma_ack); end
    n_vec++; if (o8_dma_rdata !== 32'd0) begin n_err++; $display("FAIL rir_rdata: got %h want 0", o8_dma_rdata); end
    n_vec++; if (o8_stall_count !== 16'd0) begin n_err++; $display("FAIL rir_cnt: got %h want 0", o8_stall_count); end
    @(negedge clk); #2;
    n_vec++; if (o8_dma_ack !== 1'b0) begin n_err++; $display("FAIL rir_ack_late: got %b want 0", o8_dma_ack); end
    @(negedge clk);
    cpu_cs = 1; cpu_re = 1; dma_req = 1; dma_addr = 12'h080; mem_rdata = 32'h8888_9999;
    exp_q.push_back(32'h8888_9999);
    n = 0;
    #2;
    while (o8_cpu_stall !== 1'b1 && n < 20) begin
      @(negedge clk); #2; n++;
    end
    n_vec++; if (n != 8) begin n_err++; $display("FAIL rir_blocked: got %0d want 8", n); end
    @(negedge clk); #2;
    n_vec++; if (o8_dma_ack !== 1'b1) begin n_err++; $display("FAIL rir_ack_new: got %b want 1", o8_dma_ack); end
    if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
    n_vec++; if (o8_dma_rdata !== m_rdata) begin n_err++; $display("FAIL rir_rdata_new: got %h want %h", o8_dma_rdata, m_rdata); end
    m_stall8 = m_stall8 + 16'd1;
    dma_req = 0;
    @(negedge clk); #2;
    n_vec++; if (o8_stall_count !== m_stall8) begin n_err++; $display("FAIL rir_cnt_new: got %0d want %0d", o8_stall_count, m_stall8); end
    cpu_cs = 0; cpu_re = 0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    reset = 1;
    test_reset();
    test_dma_read();
    test_dma_write();
    test_starvation();
    test_back_to_back();
    test_drop_before_grant();
    test_saturation();
    test_reset_in_resp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
